ram_rd_stream: RTL

Read-side port master for the dual-port RAM macros used in the encoder's on-chip buffers. It accepts a burst command (base address, word count), drives one RAM port with active-low chip-enable, output-enable and write-enable strobes, and absorbs the RAM's one-cycle registered read latency. The words are delivered on a valid/ready stream with a last flag. The block sits between a buffer RAM port and any downstream consumer, such as a transform or CABAC fetch unit, that may apply backpressure.

---
 rtl/ram_rd_stream.sv | 124 ++++++++++++
 1 files changed

// File: rtl/ram_rd_stream.sv
// Burst read master for a single-cycle-latency RAM port. Issued words are
// credit-limited against a 4-entry output FIFO and delivered on a valid/ready stream.
module ram_rd_stream #(
  parameter int Word_Width = 32,
  parameter int Addr_Width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [Addr_Width-1:0] base_i,
  input  logic [Addr_Width:0]   len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  cen_o,
  output logic                  oen_o,
  output logic                  wen_o,
  output logic [Addr_Width-1:0] addr_o,
  input  logic [Word_Width-1:0] data_i,
  output logic [Word_Width-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  last_o,
  output logic [1:0]            dbg_state
);

  // Stream handshake: a word transfers in any cycle where valid_o & ready_i;
  // once valid_o is high, data_o/last_o hold until that transfer happens.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [Addr_Width-1:0] addr_cnt;
  logic [Addr_Width:0]   remaining;
  logic                  cap_vld;
  logic                  cap_last;
  logic [Word_Width-1:0] fifo_data [4];
  logic [3:0]            fifo_last;
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [2:0]            occ;
  logic [3:0]            credit_used;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  last_pop;
  logic                  start_ok;

  // cap_vld is the single read in flight: issued last cycle, written this cycle.
  assign credit_used = {1'b0, occ} + {3'b000, cap_vld};
  assign start_ok    = (state == IDLE) && start_i;
  assign push        = cap_vld;
  assign valid_o     = (occ != 3'd0);
  assign pop         = valid_o && ready_i;
  assign last_pop    = pop && fifo_last[rd_ptr];
  assign data_o      = valid_o ? fifo_data[rd_ptr] : '0;
  assign last_o      = valid_o && fifo_last[rd_ptr];
  assign addr_o      = addr_cnt;
  assign wen_o       = 1'b1;
  assign dbg_state   = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i && (len_i != '0)) state_nxt = READ;
      READ:    if (issue && (remaining == 1)) state_nxt = FLUSH;
      FLUSH:   if (last_pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state != IDLE);
    oen_o  = !busy_o;
    issue  = (state == READ) && (remaining != '0) && (credit_used < 4'd4);
    cen_o  = !issue;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_cnt  <= '0;
      remaining <= '0;
      cap_vld   <= 1'b0;
      cap_last  <= 1'b0;
      fifo_last <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      done_o    <= 1'b0;
    end else begin
      done_o <= (start_ok && (len_i == '0)) || ((state == FLUSH) && last_pop);
      if (start_ok) begin
        addr_cnt  <= base_i;
        remaining <= len_i;
      end else if (issue) begin
        addr_cnt  <= addr_cnt + 1'b1;
        remaining <= remaining - 1'b1;
      end
      cap_vld  <= issue;
      cap_last <= issue && (remaining == 1);
      if (push) begin
        fifo_last[wr_ptr] <= cap_last;
        wr_ptr            <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      occ <= occ + {2'b00, push} - {2'b00, pop};
    end
  end

  // Payload storage needs no reset; data_o is masked by valid_o.
  always_ff @(posedge clk) begin
    if (push) fifo_data[wr_ptr] <= data_i;
  end

endmodule
